isolde_instr_window: RTL and testbench

Instruction word window buffer feeding the ISOLDE custom-instruction decoder. It accepts 32-bit instruction words one per cycle from the fetch path and stores them in a circular FIFO. It presents the oldest five words as a batch (`batch_o[0]` = oldest), which the decoder consumes as a variable-length instruction. The decoder pops 1..5 words at once after decoding, so multi-word instructions (quad-word load, 64-bit GEMM) are always presented contiguously and aligned at `batch_o[0]`.

---
 rtl/isolde_iwin_pkg.sv | 9 +
 rtl/isolde_iwin_store.sv | 45 ++++
 rtl/isolde_instr_window.sv | 119 +++++++++++
 tb/tb_isolde_instr_window.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/isolde_iwin_pkg.sv
// Shared types for the ISOLDE instruction window and the decoder batch input.
package isolde_iwin_pkg;

    localparam int unsigned WindowWords = 5;

    typedef logic [31:0] iwin_word_t;
    typedef iwin_word_t [WindowWords-1:0] iwin_batch_t;

endpackage

// File: rtl/isolde_iwin_store.sv
// Instruction word storage: one write port, five-word read window that wraps.
module isolde_iwin_store
    import isolde_iwin_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  iwin_word_t               wdata_i,
    input  logic [$clog2(DEPTH)-1:0] rd_ptr_i,
    input  logic [2:0]               valid_i,
    output iwin_batch_t              batch_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    iwin_word_t mem_q [DEPTH];
    iwin_word_t mem_d [DEPTH];
    logic [PtrW-1:0] idx;

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    // Storage is intentionally not reset; only pointers and count are.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_comb begin
        batch_o = '0;
        idx     = '0;
        for (int i = 0; i < WindowWords; i++) begin
            idx = rd_ptr_i + PtrW'(i);
            if (3'(i) < valid_i) begin
                batch_o[i] = mem_q[idx];
            end
        end
    end

endmodule

// File: rtl/isolde_instr_window.sv
// Circular instruction window feeding the ISOLDE decoder, variable 1..5 pop.
// Define ISOLDE_IWIN_HWM_EN to add the occupancy high-water mark port hwm_o.
module isolde_instr_window
    import isolde_iwin_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             fetch_valid_i,
    input  logic [31:0]      fetch_rdata_i,
    output logic             fetch_ready_o,
    output iwin_batch_t      batch_o,
    output logic [2:0]       batch_count_o,
    input  logic             consume_i,
    input  logic [2:0]       consume_len_i,
    output logic             error_o
`ifdef ISOLDE_IWIN_HWM_EN
    ,
    output logic [CNT_W-1:0] hwm_o
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             error_q, error_d;
    logic [2:0]       batch_count;
    logic             push;
    logic             pop_ok;

    assign batch_count = (count_q >= CNT_W'(WindowWords))
                       ? 3'(WindowWords) : count_q[2:0];

    // Readiness from registered count only: no consume-to-ready path.
    assign fetch_ready_o = (count_q < CNT_W'(DEPTH));
    assign push          = fetch_valid_i & fetch_ready_o;
    assign pop_ok        = consume_i && (consume_len_i != 3'd0)
                        && (consume_len_i <= batch_count);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        error_d  = 1'b0;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PtrW'(consume_len_i);
            end
            count_d = count_q + CNT_W'(push)
                    - (pop_ok ? CNT_W'(consume_len_i) : '0);
            error_d = consume_i & ~pop_ok;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
        end
    end

`ifdef ISOLDE_IWIN_HWM_EN
    logic [CNT_W-1:0] hwm_q, hwm_d;

    always_comb begin
        hwm_d = hwm_q;
        if (flush_i) begin
            hwm_d = '0;
        end else if (count_d > hwm_q) begin
            hwm_d = count_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm_o = hwm_q;
`endif

    assign error_o       = error_q;
    assign batch_count_o = batch_count;

    isolde_iwin_store #(
        .DEPTH (DEPTH)
    ) u_store (
        .clk_i    (clk_i),
        .we_i     (push & ~flush_i),
        .waddr_i  (wr_ptr_q),
        .wdata_i  (fetch_rdata_i),
        .rd_ptr_i (rd_ptr_q),
        .valid_i  (batch_count),
        .batch_o  (batch_o)
    );

endmodule

// File: tb/tb_isolde_instr_window.sv
// Directed vector bench for isolde_instr_window (DEPTH = 8).
module tb_isolde_instr_window;

    import isolde_iwin_pkg::*;

    typedef struct packed {
        logic        flush;
        logic        valid;
        iwin_word_t  data;
        logic        cons;
        logic [2:0]  len;
        logic        ready;
        logic [2:0]  cnt;
        iwin_batch_t batch;
        logic        err;
        logic [3:0]  hwm;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        fetch_valid_i;
    logic [31:0] fetch_rdata_i;
    logic        fetch_ready_o;
    iwin_batch_t batch_o;
    logic [2:0]  batch_count_o;
    logic        consume_i;
    logic [2:0]  consume_len_i;
    logic        error_o;
`ifdef ISOLDE_IWIN_HWM_EN
    logic [3:0]  hwm_o;
`endif

    int total = 0;
    int bad   = 0;
    vec_t vecs [31];

    always #5 clk_i = ~clk_i;

    isolde_instr_window #(
        .DEPTH (8),
        .CNT_W (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_rdata_i (fetch_rdata_i),
        .fetch_ready_o (fetch_ready_o),
        .batch_o       (batch_o),
        .batch_count_o (batch_count_o),
        .consume_i     (consume_i),
        .consume_len_i (consume_len_i),
        .error_o       (error_o)
`ifdef ISOLDE_IWIN_HWM_EN
        ,
        .hwm_o         (hwm_o)
`endif
    );

    function automatic iwin_batch_t b(input iwin_word_t w0, input iwin_word_t w1,
                                      input iwin_word_t w2, input iwin_word_t w3,
                                      input iwin_word_t w4);
        iwin_batch_t r;
        r[0] = w0;
        r[1] = w1;
        r[2] = w2;
        r[3] = w3;
        r[4] = w4;
        return r;
    endfunction

    function automatic vec_t v(input logic f, input logic vl, input iwin_word_t d,
                               input logic c, input logic [2:0] l,
                               input logic rdy, input logic [2:0] cnt,
                               input iwin_batch_t bt, input logic e,
                               input logic [3:0] h);
        vec_t r;
        r.flush = f;
        r.valid = vl;
        r.data  = d;
        r.cons  = c;
        r.len   = l;
        r.ready = rdy;
        r.cnt   = cnt;
        r.batch = bt;
        r.err   = e;
        r.hwm   = h;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [159:0] got,
                       input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic step(input logic f, input logic vl, input iwin_word_t d,
                        input logic c, input logic [2:0] l);
        flush_i       = f;
        fetch_valid_i = vl;
        fetch_rdata_i = d;
        consume_i     = c;
        consume_len_i = l;
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic rdy,
                              input logic [2:0] cnt, input iwin_batch_t bt,
                              input logic e, input logic [3:0] h);
        chk({nm, " ready"}, 160'(fetch_ready_o), 160'(rdy));
        chk({nm, " count"}, 160'(batch_count_o), 160'(cnt));
        chk({nm, " batch"}, 160'(batch_o), 160'(bt));
        chk({nm, " error"}, 160'(error_o), 160'(e));
`ifdef ISOLDE_IWIN_HWM_EN
        chk({nm, " hwm"}, 160'(hwm_o), 160'(h));
`else
        if (h > 4'd8) $display("hwm expectation out of range");
`endif
    endtask

    initial begin
        vecs[0]  = v(0,1,32'h11,0,0, 1,1,b(32'h11,0,0,0,0),0,1);
        vecs[1]  = v(0,1,32'h22,0,0, 1,2,b(32'h11,32'h22,0,0,0),0,2);
        vecs[2]  = v(0,1,32'h33,0,0, 1,3,b(32'h11,32'h22,32'h33,0,0),0,3);
        vecs[3]  = v(0,1,32'h44,0,0, 1,4,b(32'h11,32'h22,32'h33,32'h44,0),0,4);
        vecs[4]  = v(0,1,32'h55,0,0, 1,5,b(32'h11,32'h22,32'h33,32'h44,32'h55),0,5);
        vecs[5]  = v(0,1,32'h66,0,0, 1,5,b(32'h11,32'h22,32'h33,32'h44,32'h55),0,6);
        vecs[6]  = v(0,0,0,1,2, 1,4,b(32'h33,32'h44,32'h55,32'h66,0),0,6);
        vecs[7]  = v(0,1,32'h77,0,0, 1,5,b(32'h33,32'h44,32'h55,32'h66,32'h77),0,6);
        vecs[8]  = v(0,1,32'h88,0,0, 1,5,b(32'h33,32'h44,32'h55,32'h66,32'h77),0,6);
        vecs[9]  = v(0,1,32'h99,0,0, 1,5,b(32'h33,32'h44,32'h55,32'h66,32'h77),0,7);
        vecs[10] = v(0,0,0,1,4, 1,3,b(32'h77,32'h88,32'h99,0,0),0,7);
        vecs[11] = v(0,0,0,1,4, 1,3,b(32'h77,32'h88,32'h99,0,0),1,7);
        vecs[12] = v(0,0,0,0,0, 1,3,b(32'h77,32'h88,32'h99,0,0),0,7);
        vecs[13] = v(0,0,0,1,0, 1,3,b(32'h77,32'h88,32'h99,0,0),1,7);
        vecs[14] = v(0,0,0,0,0, 1,3,b(32'h77,32'h88,32'h99,0,0),0,7);
        vecs[15] = v(0,1,32'hA1,0,0, 1,4,b(32'h77,32'h88,32'h99,32'hA1,0),0,7);
        vecs[16] = v(0,1,32'hA2,0,0, 1,5,b(32'h77,32'h88,32'h99,32'hA1,32'hA2),0,7);
        vecs[17] = v(0,1,32'hA3,0,0, 1,5,b(32'h77,32'h88,32'h99,32'hA1,32'hA2),0,7);
        vecs[18] = v(0,1,32'hA4,0,0, 1,5,b(32'h77,32'h88,32'h99,32'hA1,32'hA2),0,7);
        vecs[19] = v(0,1,32'hA5,0,0, 0,5,b(32'h77,32'h88,32'h99,32'hA1,32'hA2),0,8);
        vecs[20] = v(0,1,32'hAA,1,1, 1,5,b(32'h88,32'h99,32'hA1,32'hA2,32'hA3),0,8);
        vecs[21] = v(0,1,32'hAA,0,0, 0,5,b(32'h88,32'h99,32'hA1,32'hA2,32'hA3),0,8);
        vecs[22] = v(0,0,0,1,5, 1,3,b(32'hA4,32'hA5,32'hAA,0,0),0,8);
        vecs[23] = v(0,1,32'hBB,1,1, 1,3,b(32'hA5,32'hAA,32'hBB,0,0),0,8);
        vecs[24] = v(0,1,32'hC1,0,0, 1,4,b(32'hA5,32'hAA,32'hBB,32'hC1,0),0,8);
        vecs[25] = v(0,1,32'hC2,0,0, 1,5,b(32'hA5,32'hAA,32'hBB,32'hC1,32'hC2),0,8);
        vecs[26] = v(0,1,32'hC3,0,0, 1,5,b(32'hA5,32'hAA,32'hBB,32'hC1,32'hC2),0,8);
        vecs[27] = v(1,1,32'hDD,1,2, 1,0,b(0,0,0,0,0),0,0);
        vecs[28] = v(0,1,32'hEE,0,0, 1,1,b(32'hEE,0,0,0,0),0,1);
        vecs[29] = v(1,0,0,1,4, 1,0,b(0,0,0,0,0),0,0);
        vecs[30] = v(0,0,0,0,0, 1,0,b(0,0,0,0,0),0,0);

        rst_ni        = 1'b0;
        flush_i       = 1'b0;
        fetch_valid_i = 1'b0;
        fetch_rdata_i = '0;
        consume_i     = 1'b0;
        consume_len_i = '0;
        #3;
        expect_out("reset", 1'b1, 3'd0, '0, 1'b0, 4'd0);
        #4;
        rst_ni = 1'b1;

        for (int i = 0; i < 31; i++) begin
            step(vecs[i].flush, vecs[i].valid, vecs[i].data,
                 vecs[i].cons, vecs[i].len);
            expect_out($sformatf("vec%0d", i), vecs[i].ready, vecs[i].cnt,
                       vecs[i].batch, vecs[i].err, vecs[i].hwm);
        end

        // High-water mark sequence: push 7, pop 5, push 2.
        for (int i = 0; i < 7; i++) begin
            step(0, 1, 32'hF0 + 32'(i), 0, 0);
        end
        expect_out("hwm push7", 1'b1, 3'd5,
                   b(32'hF0,32'hF1,32'hF2,32'hF3,32'hF4), 1'b0, 4'd7);
        step(0, 0, 0, 1, 5);
        expect_out("hwm pop5", 1'b1, 3'd2, b(32'hF5,32'hF6,0,0,0), 1'b0, 4'd7);
        step(0, 1, 32'hF7, 0, 0);
        step(0, 1, 32'hF8, 0, 0);
        expect_out("hwm push2", 1'b1, 3'd4,
                   b(32'hF5,32'hF6,32'hF7,32'hF8,0), 1'b0, 4'd7);
        step(0, 0, 0, 1, 5);
        expect_out("pre-reset err", 1'b1, 3'd4,
                   b(32'hF5,32'hF6,32'hF7,32'hF8,0), 1'b1, 4'd7);

        // Asynchronous reset in the middle of a cycle.
        fetch_valid_i = 1'b0;
        consume_i     = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        expect_out("mid reset", 1'b1, 3'd0, '0, 1'b0, 4'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step(0, 1, 32'h5A, 0, 0);
        expect_out("post reset", 1'b1, 3'd1, b(32'h5A,0,0,0,0), 1'b0, 4'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
